// File: rtl/bcd_pkg.sv
// Shared BCD constants and converter state encoding.
//   DIGIT_W : bits per BCD digit
//   BCD_MAX : largest legal BCD digit value
//   state_t : sequential converter states
package bcd_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

endpackage

// File: rtl/bcd_to_binary_seq_if.sv
// Handshake/data bundle for the BCD->binary converter.
//   start     : request a conversion (master -> slave)
//   bcd_in    : packed BCD digits, ones digit in the low nibble (master -> slave)
//   busy      : conversion in progress (slave -> master)
//   done      : one-cycle result-valid pulse (slave -> master)
//   bin_out   : converted value, held until the next done (slave -> master)
//   digit_err : a digit of the last conversion was >9 (slave -> master)
interface bcd_to_binary_seq_if
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned BIN_W  = 14
) ();

  logic                        start;
  logic [DIGIT_W*DIGITS-1:0]   bcd_in;
  logic                        busy;
  logic                        done;
  logic [BIN_W-1:0]            bin_out;
  logic                        digit_err;

  modport master (
    output start, bcd_in,
    input  busy, done, bin_out, digit_err
  );

  modport slave (
    input  start, bcd_in,
    output busy, done, bin_out, digit_err
  );

endinterface

// File: rtl/bcd_to_binary_seq_mul10_add.sv
// One conversion step: acc*10 + clamped digit.
//   acc_in    : running binary accumulator
//   digit_in  : next BCD digit (MSD first)
//   acc_out_c : acc_in*10 + min(digit_in, 9), truncated to BIN_W
//   err_c     : digit_in was not a legal BCD digit
module bcd_mul10_add
  import bcd_pkg::*;
#(
  parameter int unsigned BIN_W = 14
) (
  input  logic [BIN_W-1:0]   acc_in,
  input  logic [DIGIT_W-1:0] digit_in,
  output logic [BIN_W-1:0]   acc_out_c,
  output logic               err_c
);

  localparam int unsigned EXT_W = BIN_W + 4;

  logic [DIGIT_W-1:0] digit_clamped;
  logic [EXT_W-1:0]   acc_ext;

  // x10 as (x<<3)+(x<<1) in a widened domain, then truncated back
  always_comb begin
    err_c         = (digit_in > BCD_MAX);
    digit_clamped = err_c ? BCD_MAX : digit_in;
    acc_ext       = EXT_W'(acc_in);
    acc_out_c     = BIN_W'((acc_ext << 3) + (acc_ext << 1) + EXT_W'(digit_clamped));
  end

endmodule

// File: rtl/bcd_to_binary_seq.sv
// Iterative packed-BCD to binary converter, one digit per clock, MSD first.
//   clk : clock, rising edge
//   rst : asynchronous active-low reset
//   bus : slave side of bcd_to_binary_seq_if (start/bcd_in in; busy/done/bin_out/digit_err out)
module bcd_to_binary_seq
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned BIN_W  = 14
) (
  input  logic                clk,
  input  logic                rst,
  bcd_to_binary_seq_if.slave  bus
);

  localparam int unsigned SR_W  = DIGIT_W * DIGITS;
  localparam int unsigned CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIGITS - 1);

  state_t            state_q, state_d;
  logic [SR_W-1:0]   sreg_q, sreg_d;
  logic [BIN_W-1:0]  acc_q, acc_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [BIN_W-1:0]  bin_q, bin_d;
  logic              derr_q, derr_d;

  logic [BIN_W-1:0]  step_acc;
  logic              step_err;

  // Datapath step on the current top digit
  bcd_mul10_add #(.BIN_W(BIN_W)) u_step (
    .acc_in    (acc_q),
    .digit_in  (sreg_q[SR_W-1 -: DIGIT_W]),
    .acc_out_c (step_acc),
    .err_c     (step_err)
  );

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      acc_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bin_q   <= '0;
      derr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      acc_q   <= acc_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bin_q   <= bin_d;
      derr_q  <= derr_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    acc_d   = acc_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    bin_d   = bin_q;
    derr_d  = derr_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          sreg_d  = bus.bcd_in;
          acc_d   = '0;
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = CONV;
        end
      end
      CONV: begin
        acc_d  = step_acc;
        err_d  = err_q | step_err;
        sreg_d = sreg_q << DIGIT_W;
        cnt_d  = cnt_q + CNT_W'(1);
        // Last digit: publish result directly from the step outputs
        if (cnt_q == LAST) begin
          bin_d   = step_acc;
          derr_d  = err_q | step_err;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == CONV);
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.bin_out   = bin_q;
  assign bus.digit_err = derr_q;

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Self-checking bench for bcd_to_binary_seq: directed scenarios plus random
// conversions compared against a decimal-arithmetic reference model.
module tb_bcd_to_binary_seq;
  import bcd_pkg::*;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned BIN_W  = 14;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  bcd_to_binary_seq_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) bus ();

  bcd_to_binary_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference: treat each nibble as a decimal digit (clamped to 9), MSD first
  function automatic void model(input logic [15:0] v, output int unsigned val, output bit err);
    int unsigned d;
    val = 0;
    err = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      d = (int'(v) >> (4 * i)) & 15;
      if (d > 9) begin
        d = 9;
        err = 1'b1;
      end
      val = val * 10 + d;
    end
  endfunction

  // Pulse start for one edge, then watch until done (bounded)
  task automatic run_conv(input logic [15:0] v, output logic [BIN_W-1:0] b, output logic e,
                          output int lat, output int bc);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.bcd_in = v;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.bcd_in = 16'($urandom);
    lat = -1;
    bc  = 0;
    b   = '0;
    e   = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (k > 0) @(negedge clk);
      if (bus.busy) bc++;
      if (bus.done) begin
        lat = k;
        b   = bus.bin_out;
        e   = bus.digit_err;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst        = 1'b0;
    bus.start  = 1'b0;
    bus.bcd_in = '0;
    #12;
    checks++; if (bus.busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    checks++; if (bus.done !== 1'b0)      begin errors++; $display("FAIL reset_done got %b exp 0", bus.done); end
    checks++; if (bus.bin_out !== '0)     begin errors++; $display("FAIL reset_bin got %0d exp 0", bus.bin_out); end
    checks++; if (bus.digit_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", bus.digit_err); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_basic();
    logic [15:0] vals [3] = '{16'h0000, 16'h9999, 16'h1234};
    logic [BIN_W-1:0] b;
    logic e;
    int lat, bc;
    int unsigned ev;
    bit ee;
    for (int i = 0; i < 3; i++) begin
      run_conv(vals[i], b, e, lat, bc);
      model(vals[i], ev, ee);
      checks++; if (lat !== DIGITS) begin errors++; $display("FAIL basic_latency v=%h got %0d exp %0d", vals[i], lat, DIGITS); end
      checks++; if (bc !== DIGITS)  begin errors++; $display("FAIL basic_busy_cycles v=%h got %0d exp %0d", vals[i], bc, DIGITS); end
      checks++; if (b !== BIN_W'(ev)) begin errors++; $display("FAIL basic_value v=%h got %0d exp %0d", vals[i], b, ev); end
      checks++; if (e !== ee)       begin errors++; $display("FAIL basic_err v=%h got %b exp %b", vals[i], e, ee); end
      @(negedge clk);
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL basic_done_width v=%h got %b exp 0", vals[i], bus.done); end
      checks++; if (bus.bin_out !== BIN_W'(ev)) begin errors++; $display("FAIL basic_hold v=%h got %0d exp %0d", vals[i], bus.bin_out, ev); end
    end
  endtask

  task automatic test_clamp();
    logic [15:0] vals [2] = '{16'h12A4, 16'h0042};
    int unsigned expv [2] = '{1294, 42};
    bit expe [2] = '{1'b1, 1'b0};
    logic [BIN_W-1:0] b;
    logic e;
    int lat, bc;
    for (int i = 0; i < 2; i++) begin
      run_conv(vals[i], b, e, lat, bc);
      checks++; if (b !== BIN_W'(expv[i])) begin errors++; $display("FAIL clamp_value v=%h got %0d exp %0d", vals[i], b, expv[i]); end
      checks++; if (e !== expe[i]) begin errors++; $display("FAIL clamp_err v=%h got %b exp %b", vals[i], e, expe[i]); end
    end
  endtask

  task automatic test_start_while_busy();
    int ndone = 0;
    logic [BIN_W-1:0] b = '0;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.bcd_in = 16'h0500;
    @(negedge clk);
    bus.start  = 1'b0;
    for (int k = 0; k < 14; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 1) begin
        bus.start  = 1'b1;
        bus.bcd_in = 16'h0777;
      end else begin
        bus.start  = 1'b0;
      end
      if (bus.done) begin
        ndone++;
        b = bus.bin_out;
      end
    end
    checks++; if (ndone !== 1) begin errors++; $display("FAIL busy_start_dones got %0d exp 1", ndone); end
    checks++; if (b !== BIN_W'(500)) begin errors++; $display("FAIL busy_start_value got %0d exp 500", b); end
  endtask

  task automatic test_back_to_back();
    int didx [$];
    int dval [$];
    logic prev = 1'b0;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.bcd_in = 16'h0001;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus.done) begin
        checks++;
        if (prev) begin errors++; $display("FAIL b2b_done_wide at cycle %0d got 2 cycles exp 1", c); end
        didx.push_back(c);
        dval.push_back(int'(bus.bin_out));
        if (didx.size() == 1) bus.bcd_in = 16'h0002;
        if (didx.size() == 2) bus.start = 1'b0;
      end
      prev = bus.done;
    end
    bus.start = 1'b0;
    checks++;
    if (didx.size() !== 2) begin
      errors++; $display("FAIL b2b_count got %0d exp 2", didx.size());
    end else begin
      checks++; if (didx[0] !== 4) begin errors++; $display("FAIL b2b_first_at got %0d exp 4", didx[0]); end
      checks++; if (didx[1] - didx[0] !== DIGITS + 1) begin errors++; $display("FAIL b2b_period got %0d exp %0d", didx[1] - didx[0], DIGITS + 1); end
      checks++; if (dval[0] !== 1) begin errors++; $display("FAIL b2b_val0 got %0d exp 1", dval[0]); end
      checks++; if (dval[1] !== 2) begin errors++; $display("FAIL b2b_val1 got %0d exp 2", dval[1]); end
    end
  endtask

  task automatic test_async_reset();
    bit seen = 1'b0;
    logic [BIN_W-1:0] b;
    logic e;
    int lat, bc;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.bcd_in = 16'h5678;
    @(negedge clk);
    bus.start  = 1'b0;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL arst_pre_busy got %b exp 1", bus.busy); end
    #2 rst = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0)      begin errors++; $display("FAIL arst_busy got %b exp 0", bus.busy); end
    checks++; if (bus.done !== 1'b0)      begin errors++; $display("FAIL arst_done got %b exp 0", bus.done); end
    checks++; if (bus.bin_out !== '0)     begin errors++; $display("FAIL arst_bin got %0d exp 0", bus.bin_out); end
    checks++; if (bus.digit_err !== 1'b0) begin errors++; $display("FAIL arst_err got %b exp 0", bus.digit_err); end
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    checks++; if (seen) begin errors++; $display("FAIL arst_spurious_done got 1 exp 0"); end
    run_conv(16'h0357, b, e, lat, bc);
    checks++; if (b !== BIN_W'(357)) begin errors++; $display("FAIL arst_next_value got %0d exp 357", b); end
    checks++; if (lat !== DIGITS) begin errors++; $display("FAIL arst_next_latency got %0d exp %0d", lat, DIGITS); end
  endtask

  task automatic test_random();
    logic [15:0] v;
    logic [BIN_W-1:0] b;
    logic e;
    int lat, bc;
    int unsigned ev;
    bit ee;
    for (int i = 0; i < 30; i++) begin
      v = 16'($urandom);
      // Half the vectors restricted to legal digits
      if ($urandom_range(1, 0) == 0) begin
        for (int j = 0; j < 4; j++) v[4*j +: 4] = 4'($urandom_range(9, 0));
      end
      run_conv(v, b, e, lat, bc);
      model(v, ev, ee);
      checks++; if (b !== BIN_W'(ev)) begin errors++; $display("FAIL rand_value v=%h got %0d exp %0d", v, b, ev); end
      checks++; if (e !== ee) begin errors++; $display("FAIL rand_err v=%h got %b exp %b", v, e, ee); end
      checks++; if (lat !== DIGITS) begin errors++; $display("FAIL rand_latency v=%h got %0d exp %0d", v, lat, DIGITS); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clamp();
    test_start_while_busy();
    test_back_to_back();
    test_async_reset();
    test_random();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule
